dds_tuning_ctrl: RTL and testbench

DDS tuning controller that consumes the single-cycle key-press pulses from the button edge-detect stage and produces the frequency tuning word and waveform select for the phase accumulator / waveform ROM. Up/Down pulses move a target tuning word by a selectable step, with saturation. The output word glides toward the target at a programmable rate so the DDS never jumps by more than `GLIDE_INC` per update. An `Update` strobe marks every output change so the DDS core can latch the new values.

---
 rtl/dds_tuning_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dds_tuning_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_tuning_ctrl.sv
// -----------------------------------------------------------------------------
// dds_tuning_ctrl
//
// Purpose:
//   Turns single-cycle key pulses into a DDS frequency tuning word and a
//   waveform select. Up/Down move a saturating target word by the selected
//   step. The output word glides toward the target by at most GLIDE_INC
//   every GLIDE_DIV cycles, so the DDS core never sees a large jump.
//
// Ports:
//   CLK        in   system clock, single domain
//   Rst        in   synchronous active-high reset, priority over all keys
//   Key_Up     in   one-cycle pulse, raise target by current step
//   Key_Down   in   one-cycle pulse, lower target by current step
//   Key_Step   in   one-cycle pulse, advance step index (wraps 3 -> 0)
//   Key_Wave   in   one-cycle pulse, advance waveform select (wraps 3 -> 0)
//   Freq_Word  out  registered tuning word for the phase accumulator
//   Wave_Sel   out  registered waveform select (0 sine .. 3 sawtooth)
//   Step_Idx   out  registered step index
//   Update     out  one-cycle strobe marking a new Freq_Word or Wave_Sel
//   Busy       out  registered image of the FSM state (1 = GLIDE)
//
// Handshake: Update is a valid-only strobe with no ready/back-pressure. It is
// high for exactly the one cycle in which Freq_Word and/or Wave_Sel first
// show a new value; the DDS core must latch both outputs in that cycle.
// -----------------------------------------------------------------------------
module dds_tuning_ctrl #(
    parameter int              FW_W      = 32,
    parameter logic [FW_W-1:0] FW_INIT   = 85899,
    parameter logic [FW_W-1:0] FW_MIN    = 0,
    parameter logic [FW_W-1:0] FW_MAX    = 2147483647,
    parameter logic [FW_W-1:0] STEP0     = 859,
    parameter logic [FW_W-1:0] STEP1     = 8590,
    parameter logic [FW_W-1:0] STEP2     = 85899,
    parameter logic [FW_W-1:0] STEP3     = 858993,
    parameter int              GLIDE_DIV = 16,
    parameter logic [FW_W-1:0] GLIDE_INC = 65536
) (
    input  logic            CLK,
    input  logic            Rst,
    input  logic            Key_Up,
    input  logic            Key_Down,
    input  logic            Key_Step,
    input  logic            Key_Wave,
    output logic [FW_W-1:0] Freq_Word,
    output logic [1:0]      Wave_Sel,
    output logic [1:0]      Step_Idx,
    output logic            Update,
    output logic            Busy
);

    localparam int              CNT_W    = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLIDE_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GLIDE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [FW_W-1:0]   target_q, target_d;
    logic [FW_W-1:0]   freq_q, freq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        wave_q, step_idx_q;
    logic              update_q, busy_q;
    logic              glide_step;

    logic [FW_W-1:0]   step_val;
    logic [FW_W:0]     up_sum;
    logic signed [FW_W:0] down_diff;
    logic [FW_W-1:0]   gap;
    logic [FW_W-1:0]   inc;

    // Step size comes from the index before the edge, so a Key_Step in the
    // same cycle as a move does not influence that move.
    always_comb begin
        step_val = STEP0;
        case (step_idx_q)
            2'd0:    step_val = STEP0;
            2'd1:    step_val = STEP1;
            2'd2:    step_val = STEP2;
            default: step_val = STEP3;
        endcase
    end

    // Target arithmetic is one bit wider than the word so neither direction
    // can wrap before the saturation compare.
    always_comb begin
        up_sum    = {1'b0, target_q} + {1'b0, step_val};
        down_diff = $signed({1'b0, target_q}) - $signed({1'b0, step_val});
        target_d  = target_q;
        if (Key_Up && !Key_Down) begin
            target_d = (up_sum > {1'b0, FW_MAX}) ? FW_MAX : up_sum[FW_W-1:0];
        end else if (Key_Down && !Key_Up) begin
            target_d = (down_diff < $signed({1'b0, FW_MIN})) ? FW_MIN : down_diff[FW_W-1:0];
        end
    end

    // Glide FSM: next state, counter and output word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        freq_d     = freq_q;
        glide_step = 1'b0;
        gap        = (target_q > freq_q) ? (target_q - freq_q) : (freq_q - target_q);
        // Clamping the move to the remaining gap makes overshoot impossible.
        inc        = (gap > GLIDE_INC) ? GLIDE_INC : gap;
        case (state_q)
            IDLE: begin
                if (target_q != freq_q) begin
                    state_d = GLIDE;
                    cnt_d   = '0;
                end
            end
            GLIDE: begin
                if (target_q == freq_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    glide_step = 1'b1;
                    freq_d     = (target_q > freq_q) ? (freq_q + inc) : (freq_q - inc);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            target_q   <= FW_INIT;
            freq_q     <= FW_INIT;
            wave_q     <= 2'd0;
            step_idx_q <= 2'd0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            freq_q   <= freq_d;
            if (Key_Wave) begin
                wave_q <= wave_q + 2'd1;
            end
            if (Key_Step) begin
                step_idx_q <= step_idx_q + 2'd1;
            end
            // A wave change and a glide step on the same edge share one pulse.
            update_q <= glide_step | Key_Wave;
            busy_q   <= (state_d == GLIDE);
        end
    end

    assign Freq_Word = freq_q;
    assign Wave_Sel  = wave_q;
    assign Step_Idx  = step_idx_q;
    assign Update    = update_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_dds_tuning_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_tuning_ctrl
//
// Purpose:
//   Self-checking bench for dds_tuning_ctrl with small parameters
//   (16-bit word, limits 0..2000, steps 10/100/500/1000, divide 4, inc 64).
//   A reference model tracks target, output word, wave, step index and glide
//   progress with plain integer arithmetic and pushes every expected output
//   change into exp_q; a monitor pops on each Update and also compares the
//   observable outputs every cycle. Directed scenarios add absolute checks.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_dds_tuning_ctrl;

    localparam int FW_W      = 16;
    localparam int FW_INIT   = 1000;
    localparam int FW_MIN    = 0;
    localparam int FW_MAX    = 2000;
    localparam int GLIDE_DIV = 4;
    localparam int GLIDE_INC = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_up = 1'b0, key_down = 1'b0, key_step = 1'b0, key_wave = 1'b0;

    logic [FW_W-1:0] freq_word;
    logic [1:0]      wave_sel, step_idx;
    logic            update, busy;

    always #5 clk = ~clk;

    dds_tuning_ctrl #(
        .FW_W      (FW_W),
        .FW_INIT   (16'd1000),
        .FW_MIN    (16'd0),
        .FW_MAX    (16'd2000),
        .STEP0     (16'd10),
        .STEP1     (16'd100),
        .STEP2     (16'd500),
        .STEP3     (16'd1000),
        .GLIDE_DIV (GLIDE_DIV),
        .GLIDE_INC (16'd64)
    ) dut (
        .CLK       (clk),
        .Rst       (rst),
        .Key_Up    (key_up),
        .Key_Down  (key_down),
        .Key_Step  (key_step),
        .Key_Wave  (key_wave),
        .Freq_Word (freq_word),
        .Wave_Sel  (wave_sel),
        .Step_Idx  (step_idx),
        .Update    (update),
        .Busy      (busy)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int dut_updates = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int steps[4] = '{10, 100, 500, 1000};
    int m_target, m_freq, m_wave, m_step, m_phase;
    bit m_busy;
    logic [FW_W+1:0] exp_q[$];

    always @(posedge clk) begin
        int t;
        int f;
        int d;
        int mag;
        bit upd;
        if (rst) begin
            m_target = FW_INIT;
            m_freq   = FW_INIT;
            m_wave   = 0;
            m_step   = 0;
            m_phase  = 0;
            m_busy   = 1'b0;
        end else begin
            t   = m_target;
            f   = m_freq;
            upd = 1'b0;
            if (key_up && !key_down) begin
                m_target = (t + steps[m_step] > FW_MAX) ? FW_MAX : t + steps[m_step];
            end else if (key_down && !key_up) begin
                m_target = (t - steps[m_step] < FW_MIN) ? FW_MIN : t - steps[m_step];
            end
            if (key_step) m_step = (m_step + 1) % 4;
            if (key_wave) begin
                m_wave = (m_wave + 1) % 4;
                upd    = 1'b1;
            end
            // Glide: one edge to notice a mismatch, then a move every
            // GLIDE_DIV edges, and one edge to notice arrival.
            if (!m_busy) begin
                if (t != f) begin
                    m_busy  = 1'b1;
                    m_phase = 0;
                end
            end else if (t == f) begin
                m_busy = 1'b0;
            end else begin
                m_phase++;
                if (m_phase == GLIDE_DIV) begin
                    m_phase = 0;
                    d   = t - f;
                    mag = (d < 0) ? -d : d;
                    if (mag > GLIDE_INC) mag = GLIDE_INC;
                    m_freq = (d > 0) ? f + mag : f - mag;
                    upd    = 1'b1;
                end
            end
            if (upd) exp_q.push_back({2'(m_wave), 16'(m_freq)});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [FW_W+1:0] e;
        chk("freq_word", int'(freq_word), m_freq);
        chk("busy", int'(busy), int'(m_busy));
        chk("step_idx", int'(step_idx), m_step);
        chk("wave_sel", int'(wave_sel), m_wave);
        if (update) begin
            dut_updates++;
            if (exp_q.size() == 0) begin
                chk("spurious_update", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("upd_freq", int'(freq_word), int'(e[FW_W-1:0]));
                chk("upd_wave", int'(wave_sel), int'(e[FW_W+1:FW_W]));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("missing_update", 0, 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit u, input bit d, input bit s, input bit w);
        key_up = u; key_down = d; key_step = s; key_wave = w;
        @(posedge clk);
        #1;
        key_up = 0; key_down = 0; key_step = 0; key_wave = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Bounded wait for the glide to finish; an expired bound is a failure.
    task automatic wait_idle(input int max_cycles);
        int n = 0;
        idle(2);
        while (busy && n < max_cycles) begin
            idle(1);
            n++;
        end
        chk("wait_idle_timeout", int'(busy), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;

        // Test 1: reset state and a single Up step.
        do_reset();
        chk("rst_freq", int'(freq_word), 1000);
        chk("rst_wave", int'(wave_sel), 0);
        chk("rst_step", int'(step_idx), 0);
        chk("rst_update", int'(update), 0);
        chk("rst_busy", int'(busy), 0);
        press(1, 0, 0, 0);
        chk("t1_busy_e1", int'(busy), 0);
        idle(1);
        chk("t1_busy_e2", int'(busy), 1);
        idle(4);
        chk("t1_freq_e6", int'(freq_word), 1010);
        chk("t1_upd_e6", int'(update), 1);
        idle(1);
        chk("t1_busy_e7", int'(busy), 0);

        // Test 2: largest step saturates at FW_MAX; 16 glide steps.
        do_reset();
        repeat (3) press(0, 0, 1, 0);
        chk("t2_step_idx", int'(step_idx), 3);
        base = dut_updates;
        press(1, 0, 0, 0);
        idle(61);
        chk("t2_freq_e62", int'(freq_word), 1960);
        idle(4);
        chk("t2_freq_e66", int'(freq_word), 2000);
        idle(3);
        chk("t2_update_count", dut_updates - base, 16);
        chk("t2_busy_done", int'(busy), 0);
        base = dut_updates;
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        idle(4);
        chk("t2_sat_busy", int'(busy), 0);
        chk("t2_sat_updates", dut_updates - base, 0);

        // Test 3: two Downs at step 3 clamp to FW_MIN, glide to 0.
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        wait_idle(300);
        chk("t3_freq_zero", int'(freq_word), 0);
        press(0, 1, 0, 0);
        idle(4);
        chk("t3_freq_hold", int'(freq_word), 0);
        chk("t3_busy_hold", int'(busy), 0);

        // Test 4: retarget mid-glide reverses without overshoot.
        do_reset();
        repeat (3) press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        idle(9);
        chk("t4_freq_2nd", int'(freq_word), 1128);
        press(0, 1, 0, 0);
        wait_idle(100);
        chk("t4_freq_back", int'(freq_word), 1000);

        // Test 5: same-cycle events.
        do_reset();
        press(1, 1, 0, 0);
        idle(3);
        chk("t5_updown_busy", int'(busy), 0);
        chk("t5_updown_freq", int'(freq_word), 1000);
        press(1, 0, 1, 0);
        chk("t5_stepup_idx", int'(step_idx), 1);
        wait_idle(50);
        chk("t5_stepup_freq", int'(freq_word), 1010);
        for (int i = 1; i <= 5; i++) begin
            press(0, 0, 0, 1);
            chk("t5_wave_val", int'(wave_sel), i % 4);
            chk("t5_wave_upd", int'(update), 1);
            idle(1);
            chk("t5_wave_upd_low", int'(update), 0);
        end

        // Test 6: reset together with Up during a glide.
        do_reset();
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        idle(3);
        chk("t6_busy_pre", int'(busy), 1);
        rst = 1'b1;
        key_up = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        key_up = 1'b0;
        chk("t6_freq", int'(freq_word), 1000);
        chk("t6_busy", int'(busy), 0);
        chk("t6_update", int'(update), 0);
        chk("t6_step", int'(step_idx), 0);
        chk("t6_wave", int'(wave_sel), 0);
        idle(3);
        chk("t6_stay_idle", int'(busy), 0);

        // Randomized traffic checked by the model and monitor.
        for (int i = 0; i < 1500; i++) begin
            key_up   = ($urandom_range(0, 7) == 0);
            key_down = ($urandom_range(0, 7) == 0);
            key_step = ($urandom_range(0, 15) == 0);
            key_wave = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        key_up = 0; key_down = 0; key_step = 0; key_wave = 0; rst = 0;
        wait_idle(300);
        idle(2);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
